// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit master.
package spi_pkg;

   localparam int unsigned SPI_BITS = 8;
   localparam int unsigned BIT_W    = 3;
   localparam int unsigned DIV_W    = 8;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic SSEL_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } spi_state_e;

   typedef logic [SPI_BITS-1:0] spi_byte_t;

   typedef struct packed {
      logic sck;
      logic ssel;
      logic mosi;
   } spi_pins_t;

   // Line levels while no frame is in progress.
   function automatic spi_pins_t pins_idle();
      spi_pins_t p;
      p.sck  = SCK_IDLE;
      p.ssel = SSEL_IDLE;
      p.mosi = 1'b0;
      return p;
   endfunction

endpackage

// File: rtl/spi_tx_master_if.sv
// Byte stream in, SPI pins out; master modport is the transmitter side.
interface spi_tx_master_if
   import spi_pkg::*;
;
   spi_byte_t tx_data;
   logic      tx_valid;
   logic      tx_ready;
   logic      SCK;
   logic      SSEL;
   logic      MOSI;
   logic      busy;

   modport master (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output SCK,
      output SSEL,
      output MOSI,
      output busy
   );

   modport slave (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  SCK,
      input  SSEL,
      input  MOSI,
      input  busy
   );

endinterface

// File: rtl/spi_half_tick.sv
// SCK half-period divider: tick_o marks the last cycle of each half-period,
// pre_tick_o the cycle before it. Counter clears while disabled.
module spi_half_tick
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o,
   output logic pre_tick_o
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] PRE  = DIV_W'(CLK_DIV - 2);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             pre_q, pre_d;

   // Flags are registered against the count they will accompany.
   always_comb begin
      cnt_d = '0;
      if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      tick_d = en_i && (cnt_d == LAST);
      pre_d  = en_i && (cnt_d == PRE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         pre_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         pre_q  <= pre_d;
      end
   end

   assign tick_o     = tick_q;
   assign pre_tick_o = pre_q;

endmodule

// File: rtl/spi_tx_master.sv
// SPI mode-0 master transmitter: valid/ready bytes out on SCK/SSEL/MOSI,
// MSB first, back-to-back bytes merged into one SSEL-low frame.
module spi_tx_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_IDLE = 4
) (
   input  logic            clk,
   input  logic            rst,
   spi_tx_master_if.master bus
);

   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SPI_BITS - 1);
   localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CS_IDLE - 1);

   spi_state_e       state_q, state_d;
   spi_byte_t        shift_q, shift_d;
   logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
   logic [DIV_W-1:0] gap_q, gap_d;
   spi_pins_t        pins_q, pins_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;

   logic div_en;
   logic tick;
   logic pre_tick;
   logic accept;

   assign div_en = (state_q == SETUP) || (state_q == HIGH) ||
                   (state_q == LOW)   || (state_q == HOLD);
   assign accept = bus.tx_valid && tx_ready_q;

   spi_half_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_half_tick (
      .clk        (clk),
      .rst        (rst),
      .en_i       (div_en),
      .tick_o     (tick),
      .pre_tick_o (pre_tick)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bitcnt_d   = bitcnt_q;
      gap_d      = gap_q;
      pins_d     = pins_q;
      tx_ready_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = SETUP;
               shift_d     = bus.tx_data;
               bitcnt_d    = '0;
               pins_d.sck  = SCK_IDLE;
               pins_d.ssel = ~SSEL_IDLE;
               pins_d.mosi = bus.tx_data[SPI_BITS-1];
            end else begin
               tx_ready_d = 1'b1;
            end
         end

         SETUP: begin
            if (tick) begin
               state_d    = HIGH;
               pins_d.sck = 1'b1;
            end
         end

         HIGH: begin
            if (tick) begin
               state_d    = LOW;
               pins_d.sck = 1'b0;
               shift_d    = {shift_q[SPI_BITS-2:0], 1'b0};
               // On the last bit the current MSB is re-driven, holding MOSI.
               pins_d.mosi = (bitcnt_q == LAST_BIT) ? shift_q[SPI_BITS-1]
                                                    : shift_q[SPI_BITS-2];
            end
         end

         LOW: begin
            if (tick) begin
               if (bitcnt_q != LAST_BIT) begin
                  state_d    = HIGH;
                  pins_d.sck = 1'b1;
                  bitcnt_d   = bitcnt_q + BIT_W'(1);
               end else if (accept) begin
                  state_d     = HIGH;
                  pins_d.sck  = 1'b1;
                  shift_d     = bus.tx_data;
                  bitcnt_d    = '0;
                  pins_d.mosi = bus.tx_data[SPI_BITS-1];
               end else begin
                  state_d = HOLD;
               end
            end else if (pre_tick && (bitcnt_q == LAST_BIT)) begin
               tx_ready_d = 1'b1;
            end
         end

         HOLD: begin
            if (tick) begin
               state_d     = GAP;
               pins_d.ssel = SSEL_IDLE;
               pins_d.mosi = 1'b0;
               gap_d       = '0;
            end
         end

         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d    = IDLE;
               tx_ready_d = 1'b1;
            end else begin
               gap_d = gap_q + DIV_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            pins_d  = pins_idle();
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bitcnt_q   <= '0;
         gap_q      <= '0;
         pins_q     <= pins_idle();
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         gap_q      <= gap_d;
         pins_q     <= pins_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.SCK      = pins_q.sck;
   assign bus.SSEL     = pins_q.ssel;
   assign bus.MOSI     = pins_q.mosi;
   assign bus.tx_ready = tx_ready_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: two instances (CLK_DIV=4/CS_IDLE=4 and
// CLK_DIV=2/CS_IDLE=1) with a receiver model sampling MOSI on SCK rises.
module tb_spi_tx_master;

   logic clk = 1'b0;
   logic rst4;
   logic rst2;

   always #5 clk = ~clk;

   spi_tx_master_if b4 ();
   spi_tx_master_if b2 ();

   spi_tx_master #(.CLK_DIV(4), .CS_IDLE(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
   spi_tx_master #(.CLK_DIV(2), .CS_IDLE(1)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

   int checks = 0;
   int errors = 0;

   logic [1:0] sck_v, ssel_v, mosi_v, rdy_v;
   assign sck_v  = {b2.SCK,      b4.SCK};
   assign ssel_v = {b2.SSEL,     b4.SSEL};
   assign mosi_v = {b2.MOSI,     b4.MOSI};
   assign rdy_v  = {b2.tx_ready, b4.tx_ready};

   logic [1:0] prev_sck = '0;
   logic [1:0] prev_rdy = '0;
   int         cyc = 0;
   int         rx_cnt[2];
   int         cur_low[2], last_low[2], cur_high[2], last_high[2];
   int         cur_rises[2], last_rises[2], cur_rdy[2], last_rdy[2];
   int         rise_t0[2], rise_t1[2];
   logic [7:0] rx_sh[2];
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   // Receiver model and frame statistics, sampled on the falling clk edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ssel_v[i]) begin
            rx_cnt[i]   <= 0;
            cur_high[i] <= cur_high[i] + 1;
            if (cur_low[i] != 0) begin
               last_low[i]   <= cur_low[i];
               last_rises[i] <= cur_rises[i];
               last_rdy[i]   <= cur_rdy[i];
            end
            cur_low[i]   <= 0;
            cur_rises[i] <= 0;
            cur_rdy[i]   <= 0;
         end else begin
            cur_low[i] <= cur_low[i] + 1;
            if (cur_high[i] != 0) last_high[i] <= cur_high[i];
            cur_high[i] <= 0;
            if (rdy_v[i] && !prev_rdy[i]) cur_rdy[i] <= cur_rdy[i] + 1;
            if (sck_v[i] && !prev_sck[i]) begin
               rx_sh[i]     <= {rx_sh[i][6:0], mosi_v[i]};
               cur_rises[i] <= cur_rises[i] + 1;
               if (cur_rises[i] == 0) rise_t0[i] <= cyc;
               if (cur_rises[i] == 1) rise_t1[i] <= cyc;
               if (rx_cnt[i] == 7) begin
                  rx_cnt[i] <= 0;
                  if (i == 0) q0.push_back({rx_sh[i][6:0], mosi_v[i]});
                  else        q1.push_back({rx_sh[i][6:0], mosi_v[i]});
               end else begin
                  rx_cnt[i] <= rx_cnt[i] + 1;
               end
            end
         end
      end
      prev_sck <= sck_v;
      prev_rdy <= rdy_v;
      cyc      <= cyc + 1;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int idx, input logic [7:0] d, input logic v);
      if (idx == 0) begin
         b4.tx_data  = d;
         b4.tx_valid = v;
      end else begin
         b2.tx_data  = d;
         b2.tx_valid = v;
      end
   endtask

   function automatic logic rdy(input int idx);
      return (idx == 0) ? b4.tx_ready : b2.tx_ready;
   endfunction

   function automatic logic ssel(input int idx);
      return (idx == 0) ? b4.SSEL : b2.SSEL;
   endfunction

   task automatic wait_ready(input int idx, input string tag);
      int n = 0;
      while (rdy(idx) !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk_b(tag, n < 2000, 1'b1);
   endtask

   task automatic wait_ssel_high(input int idx, input string tag);
      int n = 0;
      while (ssel(idx) !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk_b(tag, n < 2000, 1'b1);
   endtask

   // Offer a byte, wait for tx_ready, step past the accepting edge, withdraw.
   task automatic send(input int idx, input logic [7:0] b);
      drive(idx, b, 1'b1);
      wait_ready(idx, "send_wait");
      tick();
      drive(idx, b, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst4 = 1'b1;
      rst2 = 1'b1;
      drive(0, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);
      tick();
      tick();

      // Reset values
      chk_b("rst_ready",  b4.tx_ready, 1'b0);
      chk_b("rst_busy",   b4.busy,     1'b0);
      chk_b("rst_ssel",   b4.SSEL,     1'b1);
      chk_b("rst_sck",    b4.SCK,      1'b0);
      chk_b("rst_mosi",   b4.MOSI,     1'b0);
      chk_b("rst2_ready", b2.tx_ready, 1'b0);
      chk_b("rst2_ssel",  b2.SSEL,     1'b1);
      rst4 = 1'b0;
      rst2 = 1'b0;
      chk_b("ready_pre_edge", b4.tx_ready, 1'b0);
      tick();
      chk_b("ready_after_rst",  b4.tx_ready, 1'b1);
      chk_b("ready2_after_rst", b2.tx_ready, 1'b1);
      chk_b("busy_after_rst",   b4.busy,     1'b0);

      // Single byte 0xA5 at CLK_DIV=4
      send(0, 8'hA5);
      chk_b("a5_ssel_low", b4.SSEL,     1'b0);
      chk_b("a5_mosi_b7",  b4.MOSI,     1'b1);
      chk_b("a5_sck_low",  b4.SCK,      1'b0);
      chk_b("a5_busy",     b4.busy,     1'b1);
      chk_b("a5_ready",    b4.tx_ready, 1'b0);
      tick(); tick(); tick();
      chk_b("a5_setup_end", b4.SCK, 1'b0);
      tick();
      chk_b("a5_first_rise", b4.SCK, 1'b1);
      wait_ssel_high(0, "a5_frame_end");
      chk_i("a5_ssel_low_len", last_low[0],   72);
      chk_i("a5_rises",        last_rises[0], 8);
      chk_i("a5_ready_pulses", last_rdy[0],   1);
      chk_i("a5_rx_count",     q0.size(),     1);
      chk_i("a5_rx_data",      32'(q0[0]),    32'hA5);
      chk_b("a5_mosi_after",   b4.MOSI,       1'b0);
      chk_b("a5_busy_gap",     b4.busy,       1'b1);
      tick(); tick(); tick();
      chk_b("a5_gap_last_busy",  b4.busy,     1'b1);
      chk_b("a5_gap_last_ready", b4.tx_ready, 1'b0);
      tick();
      chk_b("a5_idle_busy",  b4.busy,     1'b0);
      chk_b("a5_idle_ready", b4.tx_ready, 1'b1);

      // Back-to-back 0x01, 0x80 with tx_valid held
      q0.delete();
      drive(0, 8'h01, 1'b1);
      wait_ready(0, "b2b_wait1");
      tick();
      drive(0, 8'h80, 1'b1);
      chk_b("b2b_ready_mid", b4.tx_ready, 1'b0);
      wait_ready(0, "b2b_wait2");
      tick();
      drive(0, 8'h80, 1'b0);
      chk_b("b2b_ssel_held", b4.SSEL, 1'b0);
      wait_ssel_high(0, "b2b_frame_end");
      chk_i("b2b_ssel_low_len", last_low[0],   136);
      chk_i("b2b_rises",        last_rises[0], 16);
      chk_i("b2b_ready_pulses", last_rdy[0],   2);
      chk_i("b2b_rx_count",     q0.size(),     2);
      chk_i("b2b_rx_first",     32'(q0[0]),    32'h01);
      chk_i("b2b_rx_second",    32'(q0[1]),    32'h80);

      // tx_valid raised during GAP
      q0.delete();
      drive(0, 8'h3C, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk_b("gap_ready_low", b4.tx_ready, 1'b0);
         tick();
      end
      chk_b("gap_ready_idle", b4.tx_ready, 1'b1);
      tick();
      drive(0, 8'h3C, 1'b0);
      chk_b("gap_ssel_fall", b4.SSEL,     1'b0);
      chk_i("gap_high_len",  last_high[0], 5);
      wait_ssel_high(0, "gap_frame_end");
      chk_i("gap_rx_count", q0.size(),  1);
      chk_i("gap_rx_data",  32'(q0[0]), 32'h3C);

      // Reset during 0xFF after its 3rd SCK rise
      wait_ready(0, "rst_idle_wait");
      q0.delete();
      send(0, 8'hFF);
      n = 0;
      while (rx_cnt[0] != 3 && n < 2000) begin
         tick();
         n++;
      end
      chk_b("rst_third_rise_wait", n < 2000, 1'b1);
      chk_b("rst_sck_before", b4.SCK, 1'b1);
      rst4 = 1'b1;
      #1;
      chk_b("rst_async_sck",   b4.SCK,      1'b0);
      chk_b("rst_async_ssel",  b4.SSEL,     1'b1);
      chk_b("rst_async_mosi",  b4.MOSI,     1'b0);
      chk_b("rst_async_busy",  b4.busy,     1'b0);
      chk_b("rst_async_ready", b4.tx_ready, 1'b0);
      tick();
      tick();
      rst4 = 1'b0;
      chk_b("rst_rel_ready", b4.tx_ready, 1'b0);
      tick();
      chk_b("rst_rel_ready_rise", b4.tx_ready, 1'b1);
      send(0, 8'h5A);
      wait_ssel_high(0, "rst_5a_frame_end");
      chk_i("rst_rx_count", q0.size(),  1);
      chk_i("rst_rx_data",  32'(q0[0]), 32'h5A);

      // CLK_DIV=2, CS_IDLE=1, byte 0x81
      send(1, 8'h81);
      chk_b("d2_mosi_b7", b2.MOSI, 1'b1);
      wait_ssel_high(1, "d2_frame_end");
      chk_i("d2_sck_period",   rise_t1[1] - rise_t0[1], 4);
      chk_i("d2_rises",        last_rises[1], 8);
      chk_i("d2_ssel_low_len", last_low[1],   36);
      chk_i("d2_rx_count",     q1.size(),     1);
      chk_i("d2_rx_data",      32'(q1[0]),    32'h81);
      chk_b("d2_busy_gap",     b2.busy,       1'b1);
      tick();
      chk_b("d2_busy_fall",  b2.busy,     1'b0);
      chk_b("d2_ready_idle", b2.tx_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
